// File: rtl/quadrature_step_decoder_pkg.sv
// Shared types and helpers for the quadrature step decoder.
// Phases are written AB with channel A in bit 1; forward order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_decoder_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic [1:0] fwd_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] cur);
    return (cur == fwd_next(prev));
  endfunction

  function automatic logic is_rev(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == fwd_next(cur));
  endfunction

endpackage

// File: rtl/quadrature_step_decoder_glitch_filter.sv
// One encoder channel: synchroniser chain followed by a persistence filter.
// dout_sync exposes the raw synchronised level for the bypass load at the end of priming.
module glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  input  logic load,
  output logic dout,
  output logic dout_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_async};
    filt_d = filt_q;
    cnt_d  = '0;
    if (load) begin
      filt_d = synced;
    end else if (synced != filt_q) begin
      // The FILTER_LEN-th consecutive mismatch is the accepting cycle.
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = synced;
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout      = filt_q;
  assign dout_sync = synced;

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B to step/dir converter with illegal-transition flag.
// States: ST_PRIME | waiting for sync+filter pipeline to fill; ST_RUN | decoding filtered AB each cycle
module quadrature_step_decoder
  import quad_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic quad_a,
  input  logic quad_b,
  output logic step,
  output logic dir,
  output logic err,
  output logic primed
);

  localparam int PRIME_CYC = SYNC_STAGES + FILTER_LEN;
  localparam int PW        = $clog2(PRIME_CYC + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [1:0]      prev_q, prev_d;
  logic            step_q, step_d;
  logic            err_q, err_d;
  logic            dir_q, dir_d;
  logic            primed_q, primed_d;
  logic            load;
  logic            filt_a, filt_b, sync_a, sync_b;
  logic [1:0]      cur_ab, sync_ab;

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk       (clk),
    .rst       (rst),
    .din_async (quad_a),
    .load      (load),
    .dout      (filt_a),
    .dout_sync (sync_a)
  );

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk       (clk),
    .rst       (rst),
    .din_async (quad_b),
    .load      (load),
    .dout      (filt_b),
    .dout_sync (sync_b)
  );

  assign cur_ab  = {filt_a, filt_b};
  assign sync_ab = {sync_a, sync_b};

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    prev_d   = prev_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    primed_d = primed_q;
    load     = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (pcnt_q == PW'(PRIME_CYC - 1)) begin
          // Filters and prev start from the same synced value, so RUN opens with no change.
          load     = 1'b1;
          prev_d   = sync_ab;
          primed_d = 1'b1;
          pcnt_d   = '0;
          state_d  = ST_RUN;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      ST_RUN: begin
        prev_d = cur_ab;
        if (is_fwd(prev_q, cur_ab)) begin
          step_d = en;
          dir_d  = 1'b1;
        end else if (is_rev(prev_q, cur_ab)) begin
          step_d = en;
          dir_d  = 1'b0;
        end else if ((prev_q ^ cur_ab) == 2'b11) begin
          err_d = en;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PRIME;
      pcnt_q   <= '0;
      prev_q   <= PH_00;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b1;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      primed_q <= primed_d;
    end
  end

  assign step   = step_q;
  assign err    = err_q;
  assign dir    = dir_q;
  assign primed = primed_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Bench for quadrature_step_decoder: directed scenarios plus random walk, checked every cycle
// against a sample-history model; a 4-bit position counter is kept for both DUT and model.
module tb_quadrature_step_decoder;

  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int NMAX = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic quad_a = 1'b0;
  logic quad_b = 1'b0;
  logic step, dir, err, primed;

  always #5 clk = ~clk;

  quadrature_step_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .quad_a (quad_a),
    .quad_b (quad_b),
    .step   (step),
    .dir    (dir),
    .err    (err),
    .primed (primed)
  );

  // pin samples and model filtered levels, indexed by posedge number
  logic pa [NMAX];
  logic pb [NMAX];
  logic fa [NMAX];
  logic fb [NMAX];

  int k = 0;
  int last_rst = 0;
  int evt_a = 0;
  int evt_b = 0;
  int load_edge = -1;
  logic m_run = 1'b0, m_primed = 1'b0, m_dir = 1'b1, m_step = 1'b0, m_err = 1'b0;
  logic [3:0] exp_cnt = 4'd0, dut_cnt = 4'd0;
  int dut_err_n = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp_v, k);
  endtask

  // Synchronised level seen by the filter at edge kk: the pin SYNC edges earlier, 0 right after reset.
  function automatic logic synced_before(input int kk, input bit ch_b);
    if (kk - SYNC > last_rst) return ch_b ? pb[kk-SYNC] : pa[kk-SYNC];
    return 1'b0;
  endfunction

  // A new level is accepted once it has been seen for FLEN consecutive edges since the last clear.
  function automatic bit held(input int kk, input bit ch_b, input logic f, input int evt);
    if (kk - evt < FLEN) return 1'b0;
    for (int j = 0; j < FLEN; j++)
      if (synced_before(kk - j, ch_b) == f) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge(input logic r_s, input logic en_s);
    logic [1:0] cur, prv;
    int d;
    if (r_s) begin
      last_rst = k; evt_a = k; evt_b = k; load_edge = -1;
      fa[k] = 1'b0; fb[k] = 1'b0;
      m_run = 1'b0; m_primed = 1'b0; m_dir = 1'b1; m_step = 1'b0; m_err = 1'b0;
      exp_cnt = 4'd0;
      return;
    end
    fa[k] = fa[k-1];
    fb[k] = fb[k-1];
    if (held(k, 1'b0, fa[k-1], evt_a)) begin fa[k] = ~fa[k-1]; evt_a = k; end
    if (held(k, 1'b1, fb[k-1], evt_b)) begin fb[k] = ~fb[k-1]; evt_b = k; end
    m_step = 1'b0;
    m_err  = 1'b0;
    if (!m_run) begin
      if (k - last_rst == SYNC + FLEN) begin
        fa[k] = synced_before(k, 1'b0);
        fb[k] = synced_before(k, 1'b1);
        evt_a = k; evt_b = k; load_edge = k;
        m_run = 1'b1; m_primed = 1'b1;
      end
    end else begin
      cur = {fa[k-1], fb[k-1]};
      prv = (k - 2 >= load_edge) ? {fa[k-2], fb[k-2]} : {fa[load_edge], fb[load_edge]};
      d = (pos(cur) - pos(prv) + 4) % 4;
      if (d == 1) begin m_dir = 1'b1; m_step = en_s; end
      else if (d == 3) begin m_dir = 1'b0; m_step = en_s; end
      else if (d == 2) m_err = en_s;
      if (m_step) exp_cnt = m_dir ? exp_cnt + 4'd1 : exp_cnt - 4'd1;
    end
  endtask

  task automatic tick();
    logic r_s, en_s;
    @(posedge clk);
    k++;
    if (k >= NMAX) begin
      $display("FAIL edge_budget: got %0d, want < %0d", k, NMAX);
      $fatal(1, "edge budget exhausted");
    end
    pa[k] = quad_a;
    pb[k] = quad_b;
    r_s   = rst;
    en_s  = en;
    #1;
    model_edge(r_s, en_s);
    if (r_s) dut_cnt = 4'd0;
    else if (step === 1'b1) dut_cnt = dir ? dut_cnt + 4'd1 : dut_cnt - 4'd1;
    if (err === 1'b1) dut_err_n++;
    chk("step", 32'(step), 32'(m_step));
    chk("err", 32'(err), 32'(m_err));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("primed", 32'(primed), 32'(m_primed));
  endtask

  task automatic hold(input int n, input logic a, input logic b);
    quad_a = a;
    quad_b = b;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic a, input logic b);
    quad_a = a;
    quad_b = b;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat, k0, e0, r;
    logic [1:0] ab;
    fa[0] = 1'b0; fb[0] = 1'b0; pa[0] = 1'b0; pb[0] = 1'b0;

    // 1: inputs high through reset; primed after 5 cycles, no pulses
    do_reset(1'b1, 1'b1);
    repeat (4) tick();
    chk("primed_before_5", 32'(primed), 32'd0);
    tick();
    chk("primed_at_5", 32'(primed), 32'd1);
    hold(10, 1'b1, 1'b1);
    chk("idle_count", 32'(dut_cnt), 32'd0);

    // 2: forward sequence from count 0 with latency measurement
    do_reset(1'b0, 1'b0);
    hold(8, 1'b0, 1'b0);
    quad_a = 1'b1; quad_b = 1'b0;
    k0 = k + 1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step === 1'b1 && lat < 0) lat = k - k0 + 1;
    end
    chk("latency", 32'(lat), 32'd6);
    hold(10, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b0, 1'b0);
    chk("fwd_count", 32'(dut_cnt), 32'd4);

    // 3: six reverse edges, wrapping below zero
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    hold(10, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    chk("rev_count", 32'(dut_cnt), 32'd14);

    // 4: short glitch rejected, persistent change accepted
    hold(10, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    e0 = dut_err_n;
    hold(2, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0);
    chk("glitch_count", 32'(dut_cnt), 32'd12);
    chk("glitch_err", 32'(dut_err_n - e0), 32'd0);
    hold(13, 1'b1, 1'b0);
    chk("accept_count", 32'(dut_cnt), 32'd13);

    // 5: both channels change together
    hold(10, 1'b0, 1'b0);
    e0 = dut_err_n;
    hold(10, 1'b1, 1'b1);
    chk("illegal_err", 32'(dut_err_n - e0), 32'd1);
    chk("illegal_count", 32'(dut_cnt), 32'd12);

    // 6: edges while disabled, re-enable static, then reset mid-sequence
    en = 1'b0;
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b0, 1'b0);
    hold(10, 1'b1, 1'b0);
    en = 1'b1;
    hold(10, 1'b1, 1'b0);
    chk("disabled_count", 32'(dut_cnt), 32'd12);
    hold(3, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold(12, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b1);
    chk("post_reset_count", 32'(dut_cnt), 32'd1);

    // 7: random walk with glitches, illegal jumps, enable toggling and rare resets
    ab = {quad_a, quad_b};
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if (r <= 3) begin
        case (ab)
          2'b00: ab = 2'b10;
          2'b10: ab = 2'b11;
          2'b11: ab = 2'b01;
          default: ab = 2'b00;
        endcase
      end else if (r <= 7) begin
        case (ab)
          2'b00: ab = 2'b01;
          2'b01: ab = 2'b11;
          2'b11: ab = 2'b10;
          default: ab = 2'b00;
        endcase
      end else if (r == 8) begin
        ab = ~ab;
      end else begin
        hold($urandom_range(1, 2), ~ab[1], ab[0]);
      end
      hold($urandom_range(1, 8), ab[1], ab[0]);
    end
    hold(12, ab[1], ab[0]);
    chk("random_count", 32'(dut_cnt), 32'(exp_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
